scrambler_par: RTL and testbench

Parametrised 802.11a PHY scrambler/descrambler using the x^7 + x^4 + 1 LFSR. It processes W bits per beat under valid/ready flow control in both directions. In descramble mode it recovers the LFSR seed from the first 7 received bits, which are the all-zero SERVICE bits. It sits between the bit source (SIGNAL/DATA framer) and the convolutional encoder on TX, and between the Viterbi decoder and the deframer on RX. Tail-bit zeroing is not this block's job.

---
 rtl/scrambler_par.sv | 109 ++++++++++
 tb/tb_scrambler_par.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_par.sv
// 802.11a scrambler/descrambler (x^7 + x^4 + 1) processing W bits per beat with valid/ready on both sides.
// Descramble mode rebuilds the LFSR state from the all-zero SERVICE bits before switching to normal operation.
module scrambler_par #(
    parameter int W         = 1,
    parameter int SYNC_BITS = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [6:0]   seed,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [6:0]   state_out,
    output logic         locked,
    output logic         seed_err
);

    localparam int CNT_W = (SYNC_BITS < 1) ? 1 : $clog2(SYNC_BITS + 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN
    } fsm_t;

    fsm_t             state_reg;
    logic [6:0]       lfsr_reg;
    logic [6:0]       lfsr_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             out_valid_reg;
    logic [W-1:0]     out_data_reg;
    logic [W-1:0]     data_next;
    logic             seed_err_reg;
    logic             in_fire;

    assign in_ready  = (state_reg != ST_IDLE) && !start && (!out_valid_reg || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign state_out = lfsr_reg;
    assign locked    = (state_reg == ST_RUN);
    assign seed_err  = seed_err_reg;

    // One beat = W serial LFSR steps, bit 0 first. While syncing, received bits are
    // shifted straight into the state; leftover bits of that beat already run normally.
    always_comb begin
        lfsr_next = lfsr_reg;
        cnt_next  = cnt_reg;
        data_next = '0;
        for (int i = 0; i < W; i++) begin
            if ((state_reg == ST_SYNC) && (cnt_next < SYNC_END)) begin
                lfsr_next = {lfsr_next[5:0], in_data[i]};
                cnt_next  = cnt_next + CNT_ONE;
            end else begin
                data_next[i] = in_data[i] ^ lfsr_next[6] ^ lfsr_next[3];
                lfsr_next    = {lfsr_next[5:0], lfsr_next[6] ^ lfsr_next[3]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lfsr_reg      <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            seed_err_reg  <= 1'b0;
        end else begin
            seed_err_reg <= 1'b0;
            if (start) begin
                // A new frame discards any beat still waiting downstream.
                out_valid_reg <= 1'b0;
                cnt_reg       <= '0;
                if (!mode) begin
                    state_reg <= ST_RUN;
                    if (seed == 7'd0) begin
                        lfsr_reg     <= 7'h7F;
                        seed_err_reg <= 1'b1;
                    end else begin
                        lfsr_reg <= seed;
                    end
                end else begin
                    state_reg <= ST_SYNC;
                    lfsr_reg  <= '0;
                end
            end else if (in_fire) begin
                lfsr_reg      <= lfsr_next;
                cnt_reg       <= cnt_next;
                out_data_reg  <= data_next;
                out_valid_reg <= 1'b1;
                if ((state_reg == ST_SYNC) && (cnt_next == SYNC_END)) begin
                    state_reg <= ST_RUN;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scrambler_par.sv
// Scoreboard bench for scrambler_par (W = 8): stimulus pushes expected beats, a monitor pops and compares.
module tb_scrambler_par;

    localparam int W      = 8;
    localparam int NBEATS = 125;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic [6:0]   seed;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [6:0]   state_out;
    logic         locked;
    logic         seed_err;

    typedef struct {
        logic [W-1:0] data;
        bit           chk;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] cap_q[$];
    logic [W-1:0] orig[NBEATS];
    logic [W-1:0] scr[NBEATS];
    int           checks = 0;
    int           errors = 0;
    bit           bp_en  = 1'b0;

    scrambler_par #(.W(W), .SYNC_BITS(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .state_out (state_out),
        .locked    (locked),
        .seed_err  (seed_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_diff(input string name, input logic [31:0] act, input logic [31:0] avoid);
        checks++;
        if (act === avoid) begin
            errors++;
            $display("FAIL %s: got %h, required anything but %h", name, act, avoid);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output side: every handshaken beat is captured and compared against the queue head.
    task automatic run_monitor();
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_data  = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    cap_q.push_back(out_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_beat: got unexpected beat %h, required no beat", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.chk) check("out_data", 32'(out_data), 32'(e.data));
                    end
                end
                prev_stall = out_valid && !out_ready && !start;
                prev_data  = out_data;
            end
        end
    endtask

    task automatic pulse_start(input logic m, input logic [6:0] s);
        start = 1'b1;
        mode  = m;
        seed  = s;
        tick();
        start = 1'b0;
        exp_q.delete();
    endtask

    // Holds in_valid high until the beat is taken; in_valid stays high for back-to-back calls.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] e, input bit chk);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 200 && !done; n++) begin
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{data: e, chk: chk});
                done = 1'b1;
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready for beat %h, required acceptance", d);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        in_valid = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
            end else begin
                if (bp_en) out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                tick();
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        seed      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        fork
            run_monitor();
        join_none
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_seed_err", 32'(seed_err), 32'd0);
        check("rst_state_out", 32'(state_out), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Zeros through seed 7F: bit sequence 00001110 11110010
        pulse_start(1'b0, 7'h7F);
        check("scr_locked", 32'(locked), 32'd1);
        check("scr_state_seed", 32'(state_out), 32'h7F);
        send(8'h00, 8'h70, 1'b1);
        send(8'h00, 8'h4F, 1'b1);
        drain();

        // 127 beats of 8 steps = 8 full periods; no earlier beat boundary lands on the seed
        pulse_start(1'b0, 7'h5D);
        for (int i = 1; i <= 127; i++) begin
            send(8'h00, 8'h00, 1'b0);
            if (i < 127) check_diff("period_early", 32'(state_out), 32'h5D);
        end
        check("period_state", 32'(state_out), 32'h5D);
        drain();

        // Loopback: scramble a 1000-bit frame whose first 7 bits are zero, then descramble it
        for (int i = 0; i < NBEATS; i++) orig[i] = 8'($urandom);
        orig[0][6:0] = 7'd0;
        cap_q.delete();
        pulse_start(1'b0, 7'h5D);
        for (int i = 0; i < NBEATS; i++) send(orig[i], 8'h00, 1'b0);
        drain();
        check("cap_count", 32'(cap_q.size()), 32'(NBEATS));
        for (int i = 0; i < NBEATS; i++) scr[i] = (i < cap_q.size()) ? cap_q[i] : 8'h00;

        pulse_start(1'b1, 7'h00);
        check("sync_locked", 32'(locked), 32'd0);
        check("sync_state", 32'(state_out), 32'd0);
        send(scr[0], orig[0], 1'b1);
        check("sync_locked_rise", 32'(locked), 32'd1);
        for (int i = 1; i < NBEATS; i++) send(scr[i], orig[i], 1'b1);
        drain();

        // Backpressure: same scramble run with random out_ready must reproduce the stream
        bp_en = 1'b1;
        pulse_start(1'b0, 7'h5D);
        for (int i = 0; i < NBEATS; i++) send(orig[i], scr[i], 1'b1);
        drain();
        bp_en     = 1'b0;
        out_ready = 1'b1;

        // Zero seed is replaced by 7F and flagged for one cycle
        pulse_start(1'b0, 7'h00);
        check("seed_err_pulse", 32'(seed_err), 32'd1);
        check("seed_err_state", 32'(state_out), 32'h7F);
        check("seed_err_locked", 32'(locked), 32'd1);
        tick();
        check("seed_err_clear", 32'(seed_err), 32'd0);

        // Start mid-frame drops the stalled output beat
        out_ready = 1'b0;
        send(8'hAA, 8'h00, 1'b0);
        in_valid = 1'b0;
        check("pending_valid", 32'(out_valid), 32'd1);
        pulse_start(1'b0, 7'h7F);
        check("start_drops_beat", 32'(out_valid), 32'd0);

        // A beat offered during the start cycle is refused; the reload must be untouched
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        start     = 1'b1;
        mode      = 1'b0;
        seed      = 7'h7F;
        @(negedge clk);
        check("start_in_ready", 32'(in_ready), 32'd0);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("start_no_accept", 32'(out_valid), 32'd0);
        check("restart_state", 32'(state_out), 32'h7F);
        send(8'h00, 8'h70, 1'b1);
        send(8'h00, 8'h4F, 1'b1);
        drain();

        // Asynchronous reset mid-RUN with a pending beat
        out_ready = 1'b0;
        send(8'h00, 8'h00, 1'b0);
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd0);
        check("async_locked", 32'(locked), 32'd0);
        check("async_state", 32'(state_out), 32'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        tick();
        tick();
        tick();
        check("post_reset_idle_ready", 32'(in_ready), 32'd0);
        check("post_reset_idle_locked", 32'(locked), 32'd0);
        check("post_reset_no_output", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
